// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared definitions for the sequential shift-add multiplier:
//                FSM state type and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Default operand width in bits (legal range 2..64)
    localparam int c_DEFAULT_SIZE = 32;

    // Multiplier control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_unsigned_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_unsigned_nbit
//  Description : Unsigned radix-2 shift-add datapath. Holds the 2*SIZE
//                accumulator, the left-shifting multiplicand, the right-
//                shifting multiplier and the iteration counter. Exposes the
//                accumulator value that the current step produces so the
//                caller can capture the final sum on the same edge.
//                Optional macro MUL_NBIT_EARLY_EXIT_EN: flag the last step as
//                soon as the remaining multiplier becomes zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_unsigned_nbit
    import mul_pkg::*;
#(
    parameter int SIZE = c_DEFAULT_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [SIZE-1:0]     i_mcand_mag,
    input  logic [SIZE-1:0]     i_mplier_mag,
    output logic [2*SIZE-1:0]   o_acc_next,
    output logic                o_last_step
);

    localparam int             c_CW   = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SIZE - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [2*SIZE-1:0] r_acc;
    logic [2*SIZE-1:0] r_mcand;
    logic [SIZE-1:0]   r_mplier;
    logic [c_CW-1:0]   r_count;
    logic [2*SIZE-1:0] w_addend;
    logic [2*SIZE-1:0] w_acc_next;

    // Partial-product selection, accumulation and end-of-calculation detect
    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_acc_next = r_acc + w_addend;
        o_acc_next = w_acc_next;
`ifdef MUL_NBIT_EARLY_EXIT_EN
        // Once the shifted-out multiplier is empty no further additions occur
        o_last_step = (r_count == c_LAST) || (r_mplier[SIZE-1:1] == '0);
`else
        o_last_step = (r_count == c_LAST);
`endif
    end

    // Load operands on accept, otherwise advance one shift-add step per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= {{SIZE{1'b0}}, i_mcand_mag};
            r_mplier <= i_mplier_mag;
            r_count  <= '0;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*SIZE-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[SIZE-1:1]};
            r_count  <= r_count + c_ONE;
        end
    end

endmodule : mul_unsigned_nbit
`default_nettype wire

// File: rtl/mul_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_nbit
//  Description : Sequential SIZE x SIZE multiplier with per-operand signed /
//                unsigned selection and a full 2*SIZE-bit product. Operands
//                are converted to magnitudes on accept, multiplied by the
//                unsigned shift-add datapath, and the result sign is applied
//                when the product register is loaded.
//                Optional macro MUL_NBIT_EARLY_EXIT_EN: finish as soon as the
//                remaining multiplier is zero (variable latency, same result).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_nbit
    import mul_pkg::*;
#(
    parameter int SIZE = c_DEFAULT_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                ready,
    output logic                valid,
    input  logic                a_signed,
    input  logic                b_signed,
    input  logic [SIZE-1:0]     multiplicand,
    input  logic [SIZE-1:0]     multiplier,
    output logic [2*SIZE-1:0]   product
);

    mul_state_t        r_state;
    mul_state_t        w_next_state;
    logic              w_load;
    logic              w_step;
    logic              w_finish;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [SIZE-1:0]   w_a_mag;
    logic [SIZE-1:0]   w_b_mag;
    logic              r_negate;
    logic [2*SIZE-1:0] w_acc_next;
    logic              w_last_step;
    logic [2*SIZE-1:0] r_product;

    // Operand magnitudes; the most negative value negates to itself, which
    // read as unsigned is exactly 2^(SIZE-1)
    always_comb begin
        w_a_neg = a_signed & multiplicand[SIZE-1];
        w_b_neg = b_signed & multiplier[SIZE-1];
        w_a_mag = w_a_neg ? (-multiplicand) : multiplicand;
        w_b_mag = w_b_neg ? (-multiplier)   : multiplier;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and control outputs
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        valid        = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                w_step = 1'b1;
                if (w_last_step) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                valid        = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Result sign, captured together with the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_negate <= 1'b0;
        end else if (w_load) begin
            r_negate <= w_a_neg ^ w_b_neg;
        end
    end

    // Product register: loaded with the final (signed-corrected) sum on the
    // edge that enters DONE, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else if (w_finish) begin
            r_product <= r_negate ? (-w_acc_next) : w_acc_next;
        end
    end

    assign product = r_product;

    mul_unsigned_nbit #(
        .SIZE (SIZE)
    ) u_datapath (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_mcand_mag  (w_a_mag),
        .i_mplier_mag (w_b_mag),
        .o_acc_next   (w_acc_next),
        .o_last_step  (w_last_step)
    );

endmodule : mul_nbit
`default_nettype wire

// File: tb/tb_mul_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_nbit
//  Description : Self-checking bench for mul_nbit (SIZE=32) with a
//                behavioural reference model of the multiplier.
//                Honours macro MUL_NBIT_EARLY_EXIT_EN for expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_nbit;

    localparam int SIZE = 32;
`ifdef MUL_NBIT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              ready;
    logic              valid;
    logic              a_signed;
    logic              b_signed;
    logic [SIZE-1:0]   multiplicand;
    logic [SIZE-1:0]   multiplier;
    logic [2*SIZE-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mul_nbit #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ready        (ready),
        .valid        (valid),
        .a_signed     (a_signed),
        .b_signed     (b_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Full-width product from plain signed arithmetic, truncated to 2*SIZE
    function automatic logic [2*SIZE-1:0] ref_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                                  input logic as, input logic bs);
        logic signed [127:0] ea, eb, p;
        ea = as ? {{(128-SIZE){a[SIZE-1]}}, a} : {{(128-SIZE){1'b0}}, a};
        eb = bs ? {{(128-SIZE){b[SIZE-1]}}, b} : {{(128-SIZE){1'b0}}, b};
        p  = ea * eb;
        return p[2*SIZE-1:0];
    endfunction

    // Edges from accept to valid: SIZE, or with early exit the bit length of |b| (min 1)
    function automatic int lat_of(input logic [SIZE-1:0] b, input logic bs);
        logic [SIZE-1:0] m;
        int h;
        m = (bs && b[SIZE-1]) ? (-b) : b;
        if (!EARLY) return SIZE;
        h = -1;
        for (int i = 0; i < SIZE; i++) if (m[i]) h = i;
        return (h < 0) ? 1 : h + 1;
    endfunction

    task automatic chk(input string name, input logic [2*SIZE-1:0] act, input logic [2*SIZE-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: busy flag, edges since accept, pending and visible result
    bit                m_busy;
    int                m_k;
    int                m_lat;
    logic [2*SIZE-1:0] m_res;
    logic [2*SIZE-1:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_lat  <= SIZE;
            m_res  <= '0;
            m_prod <= '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_lat  <= lat_of(multiplier, b_signed);
                m_res  <= ref_mul(multiplicand, multiplier, a_signed, b_signed);
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_lat) m_prod <= m_res;
            if (m_k == m_lat) m_busy <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (ready !== !m_busy || valid !== (m_busy && m_k == m_lat) || product !== m_prod) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t ready=%b/%b valid=%b/%b product=%h/%h", $time,
                         ready, !m_busy, valid, (m_busy && m_k == m_lat), product, m_prod);
            end
        end
    end

    // One operation: wait for ready, present operands, scramble them after the
    // accepting edge, wait for valid, check latency/product and ready return
    task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic as,
                          input logic bs, input logic [2*SIZE-1:0] exp, input int exp_lat,
                          input string name, input bit noise);
        int n;
        bit got;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk({name, "_ready_timeout"}, 0, 1);
        multiplicand = a;
        multiplier   = b;
        a_signed     = as;
        b_signed     = bs;
        start        = 1'b1;
        @(posedge clk);
        #2;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        a_signed     = 1'($urandom);
        b_signed     = 1'($urandom);
        n   = 0;
        got = 1'b0;
        while (n < SIZE + 4) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid) begin
                got = 1'b1;
                break;
            end
            start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (start) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
        end
        start = 1'b0;
        chk({name, "_valid_seen"}, 64'(got), 64'd1);
        chk({name, "_latency"}, 64'(n), 64'(exp_lat));
        chk({name, "_product"}, product, exp);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_ready_back"}, 64'(ready), 64'd1);
    endtask

    initial begin
        logic [SIZE-1:0]   ra, rb;
        logic              ras, rbs;
        logic [2*SIZE-1:0] first;

        rst_n = 1'b0; start = 1'b0; a_signed = 1'b0; b_signed = 1'b0;
        multiplicand = '0; multiplier = '0;

        // Pin the model against hand-computed values
        chk("model_mixed", ref_mul(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0), 64'hFFFFFFFE00000002);
        chk("model_minneg", ref_mul(32'h80000000, 32'h80000000, 1'b1, 1'b1), 64'h4000000000000000);

        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_product", product, 64'd0);
        rst_n = 1'b1;

        // Directed cases with literal expectations
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001, SIZE, "uns_max", 1'b0);
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000, SIZE, "sgn_minneg", 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, EARLY ? 1 : SIZE, "sgn_m1x1", 1'b0);
        run_op(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFE00000002, SIZE, "mixed", 1'b0);
        run_op(32'd7, 32'd0, 1'b0, 1'b0, 64'd0, EARLY ? 1 : SIZE, "seven_x0", 1'b0);
        run_op(32'd7, 32'd1, 1'b0, 1'b0, 64'd7, EARLY ? 1 : SIZE, "seven_x1", 1'b0);

        // start pulsed during CALC with other operands must be ignored
        multiplicand = 32'h12345678; multiplier = 32'h9ABCDEF0;
        a_signed = 1'b0; b_signed = 1'b0; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        multiplicand = 32'h0000_0003; multiplier = 32'h0000_0003; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        begin
            int n;
            n = 0;
            while (!valid && n < SIZE + 4) begin
                @(negedge clk);
                n++;
            end
        end
        chk("ignored_start_valid", 64'(valid), 64'd1);
        chk("ignored_start_product", product, 64'h12345678 * 64'h9ABCDEF0);
        first = product;
        repeat (6) begin
            @(negedge clk);
            multiplicand = $urandom; multiplier = $urandom;
        end
        chk("product_hold", product, first);

        // Asynchronous reset in the middle of CALC
        @(posedge clk); #2;
        multiplicand = 32'hFFFFFFFF; multiplier = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midcalc_reset_ready", 64'(ready), 64'd1);
        chk("midcalc_reset_valid", 64'(valid), 64'd0);
        chk("midcalc_reset_product", product, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op(32'd3, 32'd5, 1'b0, 1'b0, 64'h000000000000000F, EARLY ? 3 : SIZE, "after_reset", 1'b0);

        // Back-to-back: start offered in the first IDLE cycle after DONE
        run_op(32'd10, 32'hFFFFFFF6, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFF9C, EARLY ? 4 : SIZE, "b2b", 1'b0);

        // Randomized operations against the reference model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = SIZE'($urandom_range(0, 300)); rb = SIZE'($urandom_range(0, 300)); end
                2: begin
                    ra = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'hFFFFFFFF;
                    rb = ($urandom_range(0, 1) == 1) ? 32'h00000001 : 32'h80000000;
                end
                default: begin ra = $urandom; rb = SIZE'($urandom >> $urandom_range(0, 31)); end
            endcase
            ras = 1'($urandom);
            rbs = 1'($urandom);
            run_op(ra, rb, ras, rbs, ref_mul(ra, rb, ras, rbs), lat_of(rb, rbs), "rand", 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mul_nbit
`default_nettype wire

// File: doc/mul_nbit.md
MUL_NBIT -- requirements
Module: mul_nbit

Interface
REQ-001 SHALL have parameter SIZE, default 32, giving operand width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a multiply; accepted only while ready=1.
REQ-005 SHALL have port ready  output  1  high only in IDLE.
REQ-006 SHALL have port valid  output  1  one-cycle pulse; product is valid in that cycle.
REQ-007 SHALL have port a_signed  input  1  multiplicand is two's complement when high.
REQ-008 SHALL have port b_signed  input  1  multiplier is two's complement when high.
REQ-009 SHALL have port multiplicand  input  SIZE  operand a, sampled on the accepting edge.
REQ-010 SHALL have port multiplier  input  SIZE  operand b, sampled on the accepting edge.
REQ-011 SHALL have port product  output  2*SIZE  full-width a*b; low/high halves serve MUL/MULH/MULHSU/MULHU.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 In IDLE, start=1 SHALL capture |a| and |b| as SIZE-bit unsigned magnitudes, clear the accumulator and iteration counter, and move to CALC.
REQ-014 Magnitude SHALL be the two's-complement negation when the operand's signed flag is set and its MSB is 1, otherwise the raw value; the most negative value SHALL map to 2^(SIZE-1).
REQ-015 The negate-result flag SHALL be (a_signed & a[MSB]) XOR (b_signed & b[MSB]), registered on the accepting edge.
REQ-016 Each CALC cycle SHALL run one radix-2 shift-add step: add the shifted multiplicand to the 2*SIZE accumulator if the current multiplier LSB is 1, then shift the multiplier right and the multiplicand left.
REQ-017 CALC SHALL last exactly SIZE cycles, then move to DONE.
REQ-018 On entry to DONE, product SHALL be loaded with the accumulator, negated modulo 2^(2*SIZE) when the negate flag is set.
REQ-019 In DONE, valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be fixed: with start accepted on edge 0, valid SHALL be high during cycle SIZE+1 and ready SHALL be high again from cycle SIZE+2.
REQ-021 start while ready=0 SHALL be ignored, with no effect on operands or the result.
REQ-022 product SHALL hold its last value from DONE until the next DONE or reset.
REQ-023 Operand changes after the accepting edge SHALL NOT affect the result.
REQ-024 Back-to-back: start=1 in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, ready=1, valid=0, product=0, accumulator=0, counter=0 and negate flag=0, including mid-CALC or in DONE.
REQ-026 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-027 With macro MUL_NBIT_EARLY_EXIT_EN defined, CALC SHALL move to DONE at the end of any CALC cycle in which the remaining multiplier register, after shifting, is zero, and otherwise after SIZE cycles; latency becomes 2..SIZE+1 cycles.
REQ-028 Without MUL_NBIT_EARLY_EXIT_EN, latency SHALL be fixed per REQ-020.
REQ-029 Results SHALL be identical with and without MUL_NBIT_EARLY_EXIT_EN.

Structure
REQ-030 A shared package mul_pkg SHALL hold the FSM state enum type and the default SIZE constant.
REQ-031 The unsigned shift-add datapath (accumulator, shifters, counter) SHALL be a sub-module mul_unsigned_nbit; mul_nbit SHALL contain the sign handling, FSM and output register.

Verification (SIZE=32)
REQ-032 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> product 0xFFFFFFFE00000001; valid exactly in cycle 33 after the accepting edge; ready=1 from cycle 34.
REQ-033 Signed 0x80000000*0x80000000 -> 0x4000000000000000; signed 0xFFFFFFFF*0x00000001 -> 0xFFFFFFFFFFFFFFFF.
REQ-034 Mixed (a_signed=1, b_signed=0) 0xFFFFFFFE*0xFFFFFFFF -> 0xFFFFFFFE00000002.
REQ-035 start pulsed in CALC with different operands -> ignored; first result unchanged; product stable until the next DONE.
REQ-036 rst_n low in CALC cycle 10 -> ready=1, valid=0, product=0 immediately; a new 3*5 started after release -> 0x000000000000000F.
REQ-037 With MUL_NBIT_EARLY_EXIT_EN: 7*0 -> valid in cycle 2, product 0; 7*1 -> valid in cycle 2, product 7; without the macro, both in cycle 33.
